// File: rtl/scan_result_collector.sv
// Tracks one bounded scan and reports m/steps/updates on a valid/ready record.
// Optional stream checker built when SCAN_CHECK_EN is defined.
module scan_result_collector #(
   parameter int W = 11
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] m_in,
   input  logic [W-1:0] n_in,
   input  logic [W-1:0] x_in,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [W-1:0] out_last_m,
   output logic [W-1:0] out_steps,
   output logic [W-1:0] out_updates,
   output logic         busy,
   output logic         err
);

   typedef enum logic [1:0] {
      IDLE,
      TRACK,
      REPORT,
      HOLD
   } state_t;

   localparam logic [W-1:0] MAX = '1;

   state_t       state, state_nx;
   logic [W-1:0] prev_x, prev_x_nx;
   logic [W-1:0] prev_m, prev_m_nx;
   logic [W-1:0] steps, steps_nx;
   logic [W-1:0] updates, updates_nx;
   logic [W-1:0] last_m_nx, out_steps_nx, out_updates_nx;

   function automatic logic [W-1:0] sat_inc(
      input logic [W-1:0] v,
      input logic         en
   );
      return (en && v != MAX) ? v + 1'b1 : v;
   endfunction

   always_comb begin
      state_nx       = state;
      prev_x_nx      = prev_x;
      prev_m_nx      = prev_m;
      steps_nx       = steps;
      updates_nx     = updates;
      last_m_nx      = out_last_m;
      out_steps_nx   = out_steps;
      out_updates_nx = out_updates;
      unique case (state)
         IDLE: begin
            if (x_in < n_in) begin
               prev_x_nx  = x_in;
               prev_m_nx  = m_in;
               steps_nx   = '0;
               updates_nx = '0;
               state_nx   = TRACK;
            end else begin
               last_m_nx      = m_in;
               out_steps_nx   = '0;
               out_updates_nx = '0;
               state_nx       = REPORT;
            end
         end
         TRACK: begin
            steps_nx   = sat_inc(steps, x_in != prev_x);
            updates_nx = sat_inc(updates, m_in != prev_m);
            prev_x_nx  = x_in;
            prev_m_nx  = m_in;
            if (x_in >= n_in) begin
               last_m_nx      = m_in;
               out_steps_nx   = steps_nx;
               out_updates_nx = updates_nx;
               state_nx       = REPORT;
            end
         end
         REPORT: begin
            // prev_x keeps following the stream so the checker sees steps
            prev_x_nx = x_in;
            prev_m_nx = m_in;
            if (out_ready)
               state_nx = HOLD;
         end
         HOLD: begin
            prev_x_nx = x_in;
            prev_m_nx = m_in;
            if (x_in < n_in)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         prev_x      <= '0;
         prev_m      <= '0;
         steps       <= '0;
         updates     <= '0;
         out_last_m  <= '0;
         out_steps   <= '0;
         out_updates <= '0;
         out_valid   <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nx;
         prev_x      <= prev_x_nx;
         prev_m      <= prev_m_nx;
         steps       <= steps_nx;
         updates     <= updates_nx;
         out_last_m  <= last_m_nx;
         out_steps   <= out_steps_nx;
         out_updates <= out_updates_nx;
         out_valid   <= (state_nx == REPORT);
         busy        <= (state_nx == TRACK);
      end
   end

`ifdef SCAN_CHECK_EN
   logic [W-1:0] prev_n;
   logic         viol;

   always_comb begin
      viol = 1'b0;
      if (state != IDLE) begin
         viol = (!(x_in < n_in) && !(m_in < n_in))
             || ((x_in != prev_x + 1'b1) && (x_in != prev_x))
             || (n_in != prev_n);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_n <= '0;
         err    <= 1'b0;
      end else begin
         prev_n <= n_in;
         if (viol)
            err <= 1'b1;
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_scan_result_collector.sv
// Randomized scans checked against a sample-sequence model of the record.
module tb_scan_result_collector;

   localparam int W    = 11;
   localparam int MAXC = (1 << W) - 1;
`ifdef SCAN_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic         clk;
   logic         rst;
   logic [W-1:0] m_in, n_in, x_in;
   logic         out_ready;
   logic         out_valid;
   logic [W-1:0] out_last_m, out_steps, out_updates;
   logic         busy;
   logic         err;

   int checks;
   int failures;

   scan_result_collector #(.W(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .m_in       (m_in),
      .n_in       (n_in),
      .x_in       (x_in),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_last_m (out_last_m),
      .out_steps  (out_steps),
      .out_updates(out_updates),
      .busy       (busy),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      out_ready = 1'b0;
      x_in      = '0;
      m_in      = '0;
      n_in      = 11'd200;
      step();
      chk("rst_valid", out_valid, 0);
      chk("rst_last_m", out_last_m, 0);
      chk("rst_steps", out_steps, 0);
      chk("rst_updates", out_updates, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      rst = 1'b0;
   endtask

   // mode 0: m fixed 0; 1: m follows previous x; 2: random m;
   // 3: x parked at 0 for a long stretch while m toggles
   task automatic run_scan(input int nb, input int mode,
                           input int stall, input int rwait,
                           input bit rst_first);
      int  ex_steps, ex_upd, px, pm, cx, cm, cyc, early;
      bit  done;
      bit  adv;
      if (rst_first) do_reset();
      n_in      = nb[W-1:0];
      out_ready = (rwait == 0);
      cx = 0;
      cm = (mode == 2) ? $urandom_range(nb - 1) : 0;
      x_in = cx[W-1:0];
      m_in = cm[W-1:0];
      repeat (3) step();
      chk("busy_track", busy, 1);
      ex_steps = 0;
      ex_upd   = 0;
      done     = 0;
      cyc      = 0;
      early    = 0;
      while (!done && cyc < 5000) begin
         px = cx;
         pm = cm;
         if (mode == 3) adv = (cyc >= 2100);
         else adv = ($urandom_range(99) >= stall);
         if (adv) cx++;
         case (mode)
            0: cm = 0;
            1: cm = px;
            2: if ($urandom_range(3) == 0) cm = $urandom_range(nb - 1);
            default: cm = cm ^ 1;
         endcase
         if (cx != px && ex_steps < MAXC) ex_steps++;
         if (cm != pm && ex_upd < MAXC) ex_upd++;
         x_in = cx[W-1:0];
         m_in = cm[W-1:0];
         step();
         cyc++;
         done = (cx >= nb);
         if (!done && out_valid) early++;
      end
      chk("scan_done", done, 1);
      chk("no_early_valid", early, 0);
      chk("valid_rise", out_valid, 1);
      chk("busy_report", busy, 0);
      chk("last_m", out_last_m, cm);
      chk("steps", out_steps, ex_steps);
      chk("updates", out_updates, ex_upd);
      for (int i = 0; i < rwait; i++) begin
         step();
         chk("stall_valid", out_valid, 1);
         chk("stall_last_m", out_last_m, cm);
         chk("stall_steps", out_steps, ex_steps);
         chk("stall_updates", out_updates, ex_upd);
      end
      out_ready = 1'b1;
      step();
      chk("xfer_valid", out_valid, 0);
      chk("hold_last_m", out_last_m, cm);
      chk("hold_steps", out_steps, ex_steps);
      chk("err_clean", err, 0);
      out_ready = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      out_ready = 1'b0;
      x_in = '0;
      m_in = '0;
      n_in = 11'd200;

      run_scan(200, 1, 0, 0, 1);
      run_scan(200, 0, 0, 0, 1);
      run_scan(200, 1, 0, 5, 1);
      run_scan(37, 2, 30, 2, CHK);

      // degenerate bound straight out of reset
      rst  = 1'b1;
      n_in = '0;
      x_in = '0;
      m_in = 11'd7;
      step();
      rst = 1'b0;
      step();
      chk("degen_valid", out_valid, 1);
      chk("degen_last_m", out_last_m, 7);
      chk("degen_steps", out_steps, 0);
      chk("degen_updates", out_updates, 0);
      out_ready = 1'b1;
      step();
      chk("degen_xfer", out_valid, 0);
      out_ready = 1'b0;

      // degenerate bound reached from HOLD after a real scan
      run_scan(200, 1, 0, 0, 1);
      x_in = '0;
      n_in = 11'd200;
      step();
      n_in = '0;
      m_in = 11'd9;
      step();
      chk("degen2_valid", out_valid, 1);
      chk("degen2_last_m", out_last_m, 9);
      chk("degen2_steps", out_steps, 0);
      chk("degen2_updates", out_updates, 0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // reset lands in the middle of REPORT
      do_reset();
      repeat (3) step();
      for (int i = 1; i <= 200; i++) begin
         x_in = i[W-1:0];
         m_in = 11'(i - 1);
         step();
      end
      chk("pre_rst_valid", out_valid, 1);
      rst       = 1'b1;
      out_ready = 1'b1;
      x_in = '0;
      m_in = '0;
      step();
      chk("midrst_valid", out_valid, 0);
      chk("midrst_last_m", out_last_m, 0);
      chk("midrst_steps", out_steps, 0);
      chk("midrst_updates", out_updates, 0);
      chk("midrst_busy", busy, 0);
      rst = 1'b0;
      run_scan(200, 1, 0, 0, 0);
      chk("fresh_last_m", out_last_m, 199);
      chk("fresh_steps", out_steps, 200);
      chk("fresh_updates", out_updates, 199);

      for (int k = 0; k < 8; k++) begin
         run_scan($urandom_range(60, 1), $urandom_range(2),
                  $urandom_range(50), $urandom_range(3),
                  CHK || ($urandom_range(1) == 1));
      end

      run_scan(5, 3, 0, 1, 1);
      chk("sat_updates", out_updates, MAXC);

`ifdef SCAN_CHECK_EN
      do_reset();
      repeat (3) step();
      for (int i = 1; i <= 10; i++) begin
         x_in = i[W-1:0];
         step();
      end
      chk("chk_pre_jump", err, 0);
      x_in = 11'd12;
      step();
      chk("chk_jump", err, 1);
      x_in = 11'd13;
      step();
      chk("chk_jump_sticky", err, 1);

      do_reset();
      repeat (3) step();
      for (int i = 1; i <= 5; i++) begin
         x_in = i[W-1:0];
         step();
      end
      chk("chk_pre_range", err, 0);
      x_in = 11'd200;
      m_in = 11'd250;
      step();
      chk("chk_range", err, 1);
      m_in = '0;
      out_ready = 1'b1;
      repeat (3) step();
      chk("chk_range_sticky", err, 1);
      out_ready = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
